// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter feeding WRPORTS register-file
// write ports.
// - Up to WRPORTS requesters are accepted per cycle, scanning from rr_ptr.
// - Each destination is accepted at most once per cycle.
// - Accepted writes leave on rf_dst/rf_dstv one cycle later, in scan order.
// - Unused ports, and writes to register 0, leave as dst 0 / data 0.
// Optional build macro RF_WB_SCOREBOARD_EN adds the rf_busy pending-write
// scoreboard; without it rf_busy is tied to zero.
module rf_wb_arbiter #(
  parameter int XLEN    = 1024,
  parameter int AR_BITS = 5,
  parameter int WRPORTS = 3,
  parameter int NREQ    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    wb_valid,
  input  logic [AR_BITS-1:0] wb_dst   [NREQ],
  input  logic [XLEN-1:0]    wb_data  [NREQ],
  output logic [NREQ-1:0]    wb_ready,
  output logic [AR_BITS-1:0] rf_dst   [WRPORTS],
  output logic [XLEN-1:0]    rf_dstv  [WRPORTS],
  input  logic               rsv_valid,
  input  logic [AR_BITS-1:0] rsv_dst,
  output logic [31:0]        rf_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(WRPORTS + 1);
  localparam int NDST  = 1 << AR_BITS;
  localparam logic [PTR_W:0]   NREQ_C    = (PTR_W + 1)'(NREQ);
  localparam logic [CNT_W-1:0] WRPORTS_C = CNT_W'(WRPORTS);

  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [NREQ-1:0]    ready_next;
  logic [AR_BITS-1:0] port_dst_next  [WRPORTS];
  logic [XLEN-1:0]    port_data_next [WRPORTS];
  logic [AR_BITS-1:0] rf_dst_reg     [WRPORTS];
  logic [XLEN-1:0]    rf_dstv_reg    [WRPORTS];

  // Scan temporaries for the arbitration loop.
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W:0]     scan_after;
  logic [CNT_W-1:0]   grant_cnt;
  logic [NDST-1:0]    dst_used;

  // Round-robin scan: grant, port assignment and pointer advance.
  always_comb begin
    ready_next  = '0;
    rr_ptr_next = rr_ptr_reg;
    scan_sum    = '0;
    scan_idx    = '0;
    scan_after  = '0;
    grant_cnt   = '0;
    dst_used    = '0;
    for (int p = 0; p < WRPORTS; p++) begin
      port_dst_next[p]  = '0;
      port_data_next[p] = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
      if (scan_sum >= NREQ_C) begin
        scan_sum = scan_sum - NREQ_C;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      // Reset kills every grant; duplicates of an already granted dst wait.
      if (rst_n && wb_valid[scan_idx] && (grant_cnt < WRPORTS_C) &&
          !dst_used[wb_dst[scan_idx]]) begin
        ready_next[scan_idx]     = 1'b1;
        dst_used[wb_dst[scan_idx]] = 1'b1;
        // Register-0 writes take a port slot but are emitted as idle.
        if (wb_dst[scan_idx] != '0) begin
          for (int p = 0; p < WRPORTS; p++) begin
            if (grant_cnt == CNT_W'(p)) begin
              port_dst_next[p]  = wb_dst[scan_idx];
              port_data_next[p] = wb_data[scan_idx];
            end
          end
        end
        grant_cnt  = grant_cnt + CNT_W'(1);
        scan_after = scan_sum + (PTR_W + 1)'(1);
        if (scan_after >= NREQ_C) begin
          scan_after = '0;
        end
        rr_ptr_next = scan_after[PTR_W-1:0];
      end
    end
  end

  assign wb_ready = ready_next;

  // Pointer and write-port registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      for (int p = 0; p < WRPORTS; p++) begin
        rf_dst_reg[p]  <= '0;
        rf_dstv_reg[p] <= '0;
      end
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      for (int p = 0; p < WRPORTS; p++) begin
        rf_dst_reg[p]  <= port_dst_next[p];
        rf_dstv_reg[p] <= port_data_next[p];
      end
    end
  end

  for (genvar gi = 0; gi < WRPORTS; gi++) begin : g_port_out
    assign rf_dst[gi]  = rf_dst_reg[gi];
    assign rf_dstv[gi] = rf_dstv_reg[gi];
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] busy_reg;
  logic [31:0] busy_next;

  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    logic set_bit;
    logic clr_bit;
    // Per-register flag: reserve sets, an emitted write clears, set wins.
    always_comb begin
      set_bit = rsv_valid && (gi != 0) && (32'(rsv_dst) == 32'(gi));
      clr_bit = 1'b0;
      for (int p = 0; p < WRPORTS; p++) begin
        if (32'(rf_dst_reg[p]) == 32'(gi)) begin
          clr_bit = 1'b1;
        end
      end
      busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rf_busy = busy_reg;
`else
  logic unused_rsv;
  assign unused_rsv = &{1'b0, rsv_valid, rsv_dst};
  assign rf_busy    = '0;
`endif

endmodule
